// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: read-mode enum and pointer-width helper shared by the FIFO files
package sync_fifo_pkg;
  typedef enum logic {STD, FWFT} fifo_mode_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake, status flags and error flags of sync_fifo_param
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) ();
  localparam int CW = ptr_w(DEPTH);
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             ren;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             err_clr;
  logic             overflow;
  logic             underflow;
  modport master (
    output wen, din, ren, err_clr,
    input  dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wen, din, ren, err_clr,
    output dout, dout_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: FIFO pointer with wrap bit, advancing modulo 2*DEPTH
module sync_fifo_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr + PW'(inc);
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, STD/FWFT read, thresholds; SYNC_FIFO_ERR_FLAGS_EN builds sticky error flags
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int         WIDTH     = 64,
  parameter int         DEPTH     = 8,
  parameter fifo_mode_e MODE      = STD,
  parameter int         AF_THRESH = DEPTH - 1,
  parameter int         AE_THRESH = 1
) (
  input logic clk,
  input logic reset,
  sync_fifo_param_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE = PW'(AE_THRESH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end
  logic [PW-1:0]    wr_ptr, rd_ptr, count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, rd_acc, wr_acc;
  assign empty  = wr_ptr == rd_ptr;
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_acc = f.ren & ~empty;
  // a full FIFO still takes a write when the same cycle frees a slot
  assign wr_acc = f.wen & (~full | rd_acc);
  sync_fifo_ptr #(.PW(PW)) u_wr (.clk(clk), .reset(reset), .inc(wr_acc), .ptr(wr_ptr));
  sync_fifo_ptr #(.PW(PW)) u_rd (.clk(clk), .reset(reset), .inc(rd_acc), .ptr(rd_ptr));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + PW'(wr_acc) - PW'(rd_acc);
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= f.din;
  end
  assign f.count        = count;
  assign f.full         = full;
  assign f.empty        = empty;
  assign f.almost_full  = count >= AF;
  assign f.almost_empty = count <= AE;
  if (MODE == STD) begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             dv_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
        dv_q <= rd_acc;
      end
    end
    assign f.dout       = dout_q;
    assign f.dout_valid = dv_q;
  end else begin : g_fwft
    // masking while empty keeps dout at 0 after reset instead of stale memory
    assign f.dout       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign f.dout_valid = ~empty;
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (f.wen & ~wr_acc) | (ovf_q & ~f.err_clr);
      unf_q <= (f.ren & ~rd_acc) | (unf_q & ~f.err_clr);
    end
  end
  assign f.overflow  = ovf_q;
  assign f.underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = f.err_clr;
  assign f.overflow     = 1'b0;
  assign f.underflow    = 1'b0;
`endif
endmodule
